// File: rtl/wb_csr_ctrl_pkg.sv
// Shared encodings for the writeback-stage CSR initiator.
// Exception codes, WB op encodings, CSR indices and FSM states.
package wb_csr_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUB_ADEF = 9'h000;

    localparam logic [13:0] CSR_TID = 14'h0040;

    // Bit positions inside the {ale, brk, sys, ine, adef} vector.
    localparam int EX_ADEF = 0;
    localparam int EX_INE  = 1;
    localparam int EX_SYS  = 2;
    localparam int EX_BRK  = 3;
    localparam int EX_ALE  = 4;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_CSRRD   = 3'd1,
        OP_CSRWR   = 3'd2,
        OP_CSRXCHG = 3'd3,
        OP_ERTN    = 3'd4,
        OP_RDCNTVL = 3'd5,
        OP_RDCNTVH = 3'd6,
        OP_RDCNTID = 3'd7
    } wb_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } ws_state_e;

endpackage

// File: rtl/wb_csr_ctrl_stable_counter.sv
// Free-running stable counter read by rdcntvl.w / rdcntvh.w.
// Counts every cycle and wraps naturally at the top.
module wb_csr_ctrl_stable_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         resetn,
    output logic [W-1:0] cnt
);

    // Increment unconditionally; only reset stops it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/wb_csr_ctrl.sv
// Writeback stage: CSR access, exception/ERTN commit,
// pipeline redirect and GR writeback.
module wb_csr_ctrl
    import wb_csr_ctrl_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ms_to_ws_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic [2:0]       ms_op,
    input  logic [13:0]      ms_csr_num,
    input  logic [31:0]      ms_rj_value,
    input  logic [31:0]      ms_rd_value,
    input  logic [4:0]       ms_ex_vec,
    input  logic [31:0]      ms_vaddr,
    input  logic [RF_AW-1:0] ms_dest,
    input  logic [31:0]      ms_result,
    input  logic             ms_gr_we,
    output logic             csr_re,
    output logic [13:0]      csr_num,
    input  logic [31:0]      csr_rvalue,
    output logic             csr_we,
    output logic [31:0]      csr_wmask,
    output logic [31:0]      csr_wvalue,
    output logic             wb_ex,
    output logic             ertn_flush,
    output logic [31:0]      wb_csr_pc,
    output logic [31:0]      wb_vaddr,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    input  logic             has_int,
    input  logic [31:0]      ex_entry,
    input  logic [31:0]      ertn_entry,
    output logic             flush,
    output logic [31:0]      flush_target,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [31:0]      rf_wdata
);

    typedef struct packed {
        logic [31:0]      pc;
        wb_op_e           op;
        logic [13:0]      csr_num;
        logic [31:0]      rj_value;
        logic [31:0]      rd_value;
        logic [4:0]       ex_vec;
        logic [31:0]      vaddr;
        logic [RF_AW-1:0] dest;
        logic [31:0]      result;
        logic             gr_we;
    } ws_t;

    ws_t              ms_bundle;
    ws_t              ws;
    logic             ws_valid;
    logic             ready_go;
    logic             take_ex;
    logic             csr_go;
    ws_state_e        state;
    ws_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;

    assign ready_go = 1'b1;

    assign ms_bundle = '{
        pc:       ms_pc,
        op:       wb_op_e'(ms_op),
        csr_num:  ms_csr_num,
        rj_value: ms_rj_value,
        rd_value: ms_rd_value,
        ex_vec:   ms_ex_vec,
        vaddr:    ms_vaddr,
        dest:     ms_dest,
        result:   ms_result,
        gr_we:    ms_gr_we
    };

    wb_csr_ctrl_stable_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .cnt    (cnt)
    );

    // WB register: a flush kills the resident op and any
    // instruction offered in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            ws       <= '0;
        end else if (flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                ws <= ms_bundle;
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // One DRAIN cycle after every flush blocks stale MEM traffic.
    always_comb begin
        state_nxt  = state;
        ws_allowin = 1'b0;
        unique case (state)
            ST_RUN: begin
                ws_allowin = !ws_valid || ready_go;
                if (flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Exception priority: interrupt, then adef, ine, sys, brk, ale.
    always_comb begin
        take_ex     = ws_valid && (has_int || (|ws.ex_vec));
        wb_ecode    = 6'h0;
        wb_esubcode = 9'h0;
        if (take_ex) begin
            if (has_int) begin
                wb_ecode = ECODE_INT;
            end else if (ws.ex_vec[EX_ADEF]) begin
                wb_ecode    = ECODE_ADE;
                wb_esubcode = ESUB_ADEF;
            end else if (ws.ex_vec[EX_INE]) begin
                wb_ecode = ECODE_INE;
            end else if (ws.ex_vec[EX_SYS]) begin
                wb_ecode = ECODE_SYS;
            end else if (ws.ex_vec[EX_BRK]) begin
                wb_ecode = ECODE_BRK;
            end else begin
                wb_ecode = ECODE_ALE;
            end
        end
    end

    assign wb_ex      = take_ex;
    assign wb_csr_pc  = ws.pc;
    assign wb_vaddr   = ws.vaddr;
    assign ertn_flush = ws_valid && (ws.op == OP_ERTN) && !take_ex;
    assign flush      = wb_ex || ertn_flush;

    assign flush_target = wb_ex      ? ex_entry   :
                          ertn_flush ? ertn_entry : 32'h0;

    // Side effects only for a live, non-excepting instruction.
    assign csr_go = ws_valid && !take_ex;

    // CSR port: reads return the old value, writes use mask/value.
    always_comb begin
        csr_re     = 1'b0;
        csr_num    = 14'h0;
        csr_we     = 1'b0;
        csr_wmask  = 32'h0;
        csr_wvalue = 32'h0;
        if (csr_go) begin
            unique case (ws.op)
                OP_CSRRD: begin
                    csr_re  = 1'b1;
                    csr_num = ws.csr_num;
                end
                OP_CSRWR: begin
                    csr_re     = 1'b1;
                    csr_num    = ws.csr_num;
                    csr_we     = 1'b1;
                    csr_wmask  = 32'hFFFF_FFFF;
                    csr_wvalue = ws.rd_value;
                end
                OP_CSRXCHG: begin
                    csr_re     = 1'b1;
                    csr_num    = ws.csr_num;
                    csr_we     = 1'b1;
                    csr_wmask  = ws.rj_value;
                    csr_wvalue = ws.rd_value;
                end
                OP_RDCNTID: begin
                    csr_re  = 1'b1;
                    csr_num = CSR_TID;
                end
                default: begin
                end
            endcase
        end
    end

    // GR writeback data select.
    always_comb begin
        rf_we    = csr_go && ws.gr_we;
        rf_waddr = '0;
        rf_wdata = 32'h0;
        if (rf_we) begin
            rf_waddr = ws.dest;
            unique case (ws.op)
                OP_CSRRD,
                OP_CSRWR,
                OP_CSRXCHG,
                OP_RDCNTID: rf_wdata = csr_rvalue;
                OP_RDCNTVL: rf_wdata = cnt[31:0];
                OP_RDCNTVH: rf_wdata = cnt[63:32];
                default:    rf_wdata = ws.result;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Randomized bench for wb_csr_ctrl against a cycle-level
// behavioural model of the writeback stage.
module tb_wb_csr_ctrl;

    typedef struct packed {
        logic        rstn;
        logic        mv;
        logic [31:0] pc;
        logic [2:0]  op;
        logic [13:0] num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic [4:0]  exv;
        logic [31:0] va;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        gwe;
        logic        hint;
        logic [31:0] rval;
        logic [31:0] exe;
        logic [31:0] erte;
    } stim_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [2:0]  ms_op;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_rj_value;
    logic [31:0] ms_rd_value;
    logic [4:0]  ms_ex_vec;
    logic [31:0] ms_vaddr;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_gr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        flush;
    logic [31:0] flush_target;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: what is resident in WB, drain cycle
    // pending, and cycles elapsed since the last reset edge.
    logic        m_live  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_drain = 1'b0;
    stim_t       m_ins   = '0;
    logic [63:0] m_cnt   = 64'h0;

    // Exception code indexed by ex_vec bit; lower bit wins.
    logic [5:0] code_of [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    always #5 clk = ~clk;

    wb_csr_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_pc          (ms_pc),
        .ms_op          (ms_op),
        .ms_csr_num     (ms_csr_num),
        .ms_rj_value    (ms_rj_value),
        .ms_rd_value    (ms_rd_value),
        .ms_ex_vec      (ms_ex_vec),
        .ms_vaddr       (ms_vaddr),
        .ms_dest        (ms_dest),
        .ms_result      (ms_result),
        .ms_gr_we       (ms_gr_we),
        .csr_re         (csr_re),
        .csr_num        (csr_num),
        .csr_rvalue     (csr_rvalue),
        .csr_we         (csr_we),
        .csr_wmask      (csr_wmask),
        .csr_wvalue     (csr_wvalue),
        .wb_ex          (wb_ex),
        .ertn_flush     (ertn_flush),
        .wb_csr_pc      (wb_csr_pc),
        .wb_vaddr       (wb_vaddr),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .has_int        (has_int),
        .ex_entry       (ex_entry),
        .ertn_entry     (ertn_entry),
        .flush          (flush),
        .flush_target   (flush_target),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.rstn = 1'b1;
        s.exe  = 32'h1C00_8000;
        s.erte = 32'h1C00_0400;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s      = idle();
        s.rstn = ($urandom_range(0, 299) != 0);
        s.mv   = ($urandom_range(0, 9) < 8);
        s.pc   = $urandom & 32'hFFFF_FFFC;
        s.op   = 3'($urandom_range(0, 7));
        s.num  = 14'($urandom);
        s.rj   = $urandom;
        s.rd   = $urandom;
        s.exv  = ($urandom_range(0, 9) < 7) ? 5'd0 : 5'($urandom);
        s.va   = $urandom;
        s.dest = 5'($urandom);
        s.res  = $urandom;
        s.gwe  = 1'($urandom);
        s.hint = ($urandom_range(0, 15) == 0);
        s.rval = $urandom;
        s.exe  = $urandom;
        s.erte = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        resetn         = s.rstn;
        ms_to_ws_valid = s.mv;
        ms_pc          = s.pc;
        ms_op          = s.op;
        ms_csr_num     = s.num;
        ms_rj_value    = s.rj;
        ms_rd_value    = s.rd;
        ms_ex_vec      = s.exv;
        ms_vaddr       = s.va;
        ms_dest        = s.dest;
        ms_result      = s.res;
        ms_gr_we       = s.gwe;
        has_int        = s.hint;
        csr_rvalue     = s.rval;
        ex_entry       = s.exe;
        ertn_entry     = s.erte;
    endtask

    // One clock: drive, compare against the model, then clock
    // both DUT and model forward.
    task automatic step(input stim_t s, input string tag);
        logic        take, ert, fl, go, is_csr, re, we, rwe;
        logic [5:0]  ecode;
        logic [31:0] tgt, wmask, wdata;
        logic [13:0] num;
        drive(s);
        #1;
        take  = m_valid && (s.hint || (|m_ins.exv));
        ecode = 6'h0;
        if (take && !s.hint) begin
            for (int i = 4; i >= 0; i--) begin
                if (m_ins.exv[i]) ecode = code_of[i];
            end
        end
        ert    = m_valid && (m_ins.op == 3'd4) && !take;
        fl     = take || ert;
        tgt    = take ? s.exe : (ert ? s.erte : 32'h0);
        go     = m_valid && !take;
        is_csr = (m_ins.op >= 3'd1) && (m_ins.op <= 3'd3);
        re     = go && (is_csr || m_ins.op == 3'd7);
        num    = !re ? 14'h0 : (m_ins.op == 3'd7 ? 14'h40 : m_ins.num);
        we     = go && (m_ins.op == 3'd2 || m_ins.op == 3'd3);
        wmask  = !we ? 32'h0 :
                 (m_ins.op == 3'd2 ? 32'hFFFF_FFFF : m_ins.rj);
        rwe    = go && m_ins.gwe;
        if (is_csr || m_ins.op == 3'd7) wdata = s.rval;
        else if (m_ins.op == 3'd5)      wdata = m_cnt[31:0];
        else if (m_ins.op == 3'd6)      wdata = m_cnt[63:32];
        else                            wdata = m_ins.res;
        if (m_live) begin
            check({tag, ".allowin"}, 64'(ws_allowin), 64'(!m_drain));
            check({tag, ".wb_ex"}, 64'(wb_ex), 64'(take));
            check({tag, ".ertn"}, 64'(ertn_flush), 64'(ert));
            check({tag, ".ecode"}, 64'(wb_ecode), 64'(ecode));
            check({tag, ".esub"}, 64'(wb_esubcode), 64'h0);
            check({tag, ".flush"}, 64'(flush), 64'(fl));
            check({tag, ".target"}, 64'(flush_target), 64'(tgt));
            check({tag, ".csr_re"}, 64'(csr_re), 64'(re));
            check({tag, ".csr_num"}, 64'(csr_num), 64'(num));
            check({tag, ".csr_we"}, 64'(csr_we), 64'(we));
            check({tag, ".wmask"}, 64'(csr_wmask), 64'(wmask));
            check({tag, ".wvalue"}, 64'(csr_wvalue),
                  64'(we ? m_ins.rd : 32'h0));
            check({tag, ".rf_we"}, 64'(rf_we), 64'(rwe));
            if (rwe) begin
                check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_ins.dest));
                check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(wdata));
            end
            if (take) begin
                check({tag, ".era"}, 64'(wb_csr_pc), 64'(m_ins.pc));
                check({tag, ".badv"}, 64'(wb_vaddr), 64'(m_ins.va));
            end
        end
        @(posedge clk);
        #1;
        if (!s.rstn) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_drain = 1'b0;
            m_cnt   = 64'h0;
        end else begin
            m_cnt = m_cnt + 64'h1;
            if (fl) begin
                m_valid = 1'b0;
                m_drain = 1'b1;
            end else if (m_drain) begin
                m_drain = 1'b0;
            end else begin
                m_valid = s.mv;
                if (s.mv) m_ins = s;
            end
        end
    endtask

    initial begin
        stim_t s;

        s      = idle();
        s.rstn = 1'b0;
        step(s, "rst");
        step(s, "rst");

        s = idle();
        step(s, "after_rst");

        // rdcntvl a few cycles after reset, then rdcntvh.
        s = idle(); s.mv = 1'b1; s.op = 3'd5; s.gwe = 1'b1; s.dest = 5'd4;
        step(s, "cntvl_issue");
        s = idle(); s.mv = 1'b1; s.op = 3'd6; s.gwe = 1'b1; s.dest = 5'd6;
        step(s, "cntvl_wb");
        s = idle();
        step(s, "cntvh_wb");

        // csrwr CRMD: write 7, old value 8 comes back on the GR port.
        s = idle(); s.mv = 1'b1; s.op = 3'd2; s.num = 14'h0;
        s.rd = 32'h7; s.gwe = 1'b1; s.dest = 5'd5;
        step(s, "csrwr_issue");
        s = idle(); s.rval = 32'h8;
        step(s, "csrwr_wb");

        // csrxchg with a byte mask.
        s = idle(); s.mv = 1'b1; s.op = 3'd3; s.num = 14'h30;
        s.rj = 32'h0000_FF00; s.rd = 32'h1234_5678; s.gwe = 1'b1;
        s.dest = 5'd9;
        step(s, "xchg_issue");
        s = idle(); s.rval = 32'hCAFE_0001;
        step(s, "xchg_wb");

        // sys+ale together: sys wins, then one drain cycle.
        s = idle(); s.mv = 1'b1; s.op = 3'd2; s.pc = 32'h1C00_0100;
        s.exv = 5'b10100; s.va = 32'h0000_0123; s.gwe = 1'b1;
        step(s, "sysale_issue");
        s = idle(); s.mv = 1'b1; s.op = 3'd1; s.gwe = 1'b1;
        step(s, "sysale_wb");
        s = idle(); s.mv = 1'b1; s.op = 3'd1; s.gwe = 1'b1;
        step(s, "sysale_drain");
        s = idle();
        step(s, "sysale_run");

        // Interrupt on a csrwr; MEM op offered in that cycle is lost.
        s = idle(); s.mv = 1'b1; s.op = 3'd2; s.pc = 32'h1C00_0040;
        s.gwe = 1'b1; s.dest = 5'd3;
        step(s, "int_issue");
        s = idle(); s.hint = 1'b1; s.mv = 1'b1; s.op = 3'd0;
        s.gwe = 1'b1; s.res = 32'h55;
        step(s, "int_wb");
        s = idle();
        step(s, "int_drain");
        step(s, "int_run");

        // ertn, then ertn with adef.
        s = idle(); s.mv = 1'b1; s.op = 3'd4;
        step(s, "ertn_issue");
        s = idle(); s.erte = 32'h1C00_0200;
        step(s, "ertn_wb");
        step(s, "ertn_drain");
        s = idle(); s.mv = 1'b1; s.op = 3'd4; s.exv = 5'b00001;
        s.pc = 32'h1C00_0300;
        step(s, "ertnadef_issue");
        s = idle(); s.erte = 32'h1C00_0200;
        step(s, "ertnadef_wb");

        // Reset asserted during the drain cycle.
        s = idle(); s.rstn = 1'b0;
        step(s, "drain_rst");
        s = idle();
        step(s, "drain_rst_run");

        // rdcntid reads TID.
        s = idle(); s.mv = 1'b1; s.op = 3'd7; s.gwe = 1'b1; s.dest = 5'd1;
        step(s, "tid_issue");
        s = idle(); s.rval = 32'h0000_0042;
        step(s, "tid_wb");

        for (int i = 0; i < 3000; i++) begin
            step(rnd(), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
